// File: rtl/port_bus_ctrl.sv
// Sequencer/arbiter for the 8-bit bidirectional port pair: round-robin between a
// write and a read requester, owns in_out_en and inserts turnaround cycles on direction change.
module port_bus_ctrl #(
    parameter int unsigned WR_HOLD  = 2,
    parameter int unsigned RD_WAIT  = 2,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       wr_req,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    input  logic       rd_req,
    output logic [7:0] rd_data,
    output logic       rd_ack,
    output logic [7:0] port_d,
    input  logic [7:0] port_q_out,
    output logic       in_out_en,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TURN  = 2'd1,
        S_WRITE = 2'd2,
        S_READ  = 2'd3
    } state_e;

    localparam logic [3:0] WR_LOAD   = 4'(WR_HOLD - 32'd1);
    localparam logic [3:0] RD_LOAD   = 4'(RD_WAIT - 32'd1);
    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYC - 32'd1);
    localparam logic       HAS_TURN  = (TURN_CYC != 32'd0);

    state_e     state_q, state_d;
    logic       dir_q, dir_d;
    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] port_d_q, port_d_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       ioe_q, ioe_d;
    logic       wr_ack_q, wr_ack_d;
    logic       rd_ack_q, rd_ack_d;
    logic       busy_q, busy_d;

    logic       grant_wr_s;
    logic       grant_rd_s;
    logic       arb_ok_s;

    // Round-robin: on contention the side not granted last wins; last_q=0 favours write.
    always_comb begin
        grant_wr_s = wr_req & (~rd_req | ~last_q);
        grant_rd_s = rd_req & ~grant_wr_s;
        arb_ok_s   = (state_q == S_IDLE) & ~wr_ack_q & ~rd_ack_q;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        port_d_d  = port_d_q;
        rd_data_d = rd_data_q;
        ioe_d     = 1'b0;
        wr_ack_d  = 1'b0;
        rd_ack_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb_ok_s && (grant_wr_s || grant_rd_s)) begin
                    last_d = grant_wr_s;
                    if (grant_wr_s) begin
                        port_d_d = wr_data;
                    end else begin
                        port_d_d = port_d_q;
                    end
                    if ((grant_wr_s != dir_q) && HAS_TURN) begin
                        state_d = S_TURN;
                        cnt_d   = TURN_LOAD;
                    end else if (grant_wr_s) begin
                        dir_d   = 1'b1;
                        state_d = S_WRITE;
                        cnt_d   = WR_LOAD;
                        ioe_d   = 1'b1;
                    end else begin
                        dir_d   = 1'b0;
                        state_d = S_READ;
                        cnt_d   = RD_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            // last_q still names the pending operation while turning around.
            S_TURN: begin
                if (cnt_q == 4'd0) begin
                    dir_d = last_q;
                    if (last_q) begin
                        state_d = S_WRITE;
                        cnt_d   = WR_LOAD;
                        ioe_d   = 1'b1;
                    end else begin
                        state_d = S_READ;
                        cnt_d   = RD_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d  = S_IDLE;
                    wr_ack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    ioe_d = 1'b1;
                end
            end
            S_READ: begin
                if (cnt_q == 4'd0) begin
                    state_d   = S_IDLE;
                    rd_ack_d  = 1'b1;
                    rd_data_d = port_q_out;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; clear aborts any operation and releases the bus at once.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q   <= S_IDLE;
            dir_q     <= 1'b0;
            last_q    <= 1'b0;
            cnt_q     <= 4'd0;
            port_d_q  <= 8'd0;
            rd_data_q <= 8'd0;
            ioe_q     <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            port_d_q  <= port_d_d;
            rd_data_q <= rd_data_d;
            ioe_q     <= ioe_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_ack    = wr_ack_q;
    assign rd_ack    = rd_ack_q;
    assign rd_data   = rd_data_q;
    assign port_d    = port_d_q;
    assign in_out_en = ioe_q;
    assign busy      = busy_q;

endmodule
